// File: rtl/data_bucket_sync.sv
// Terminal sink for a 4-phase bundled-data channel: synchronizes r_req, captures packets, acks, counts.
// Optional `DB_SIGNATURE_EN adds a rotate-XOR running signature output `sig`.
module data_bucket_sync #(
  parameter int WIDTH = 57,
  parameter int BL    = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sink_en,
  input  logic             r_req,
  input  logic [WIDTH-1:0] r_data,
  output logic             r_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] pkt_count,
  output logic             busy,
  output logic             proto_err,
  output logic [1:0]       dbg_state
`ifdef DB_SIGNATURE_EN
  ,
  output logic [WIDTH-1:0] sig
`endif
);

  // Handshake: r_req rises with r_data stable; the sink captures once, raises r_ack,
  // the sender drops r_req, then the sink drops r_ack (return-to-zero) before the next capture.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACK_HI = 2'd2,
    ACK_LO = 2'd3
  } state_t;

  localparam logic [7:0] DLY_LOAD = (BL > 0) ? 8'(BL - 1) : 8'd0;

  state_t           state_q, state_d;
  logic             req_meta_q, req_meta_d;
  logic             req_s_q, req_s_d;
  logic [7:0]       dly_q, dly_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             dv_q, dv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perr_q, perr_d;
  logic             capture;

  assign req_meta_d = r_req;
  assign req_s_d    = req_meta_q;
  assign capture    = (state_q == IDLE) && req_s_q && sink_en;

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    data_out_d = data_out_q;
    dv_d       = 1'b0;
    cnt_d      = cnt_q;
    perr_d     = perr_q;
    // r_ack follows the state one cycle late so it comes straight from a flop
    ack_d      = (state_q == ACK_HI);
    case (state_q)
      IDLE: begin
        if (capture) begin
          data_out_d = r_data;
          dv_d       = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          dly_d      = DLY_LOAD;
          state_d    = (BL == 0) ? ACK_HI : DELAY;
        end
      end
      DELAY: begin
        if (!req_s_q) begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end else if (dly_q == 8'd0) begin
          state_d = ACK_HI;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      ACK_HI: begin
        if (!req_s_q) state_d = ACK_LO;
      end
      ACK_LO: begin
        if (!req_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      dly_q      <= 8'd0;
      ack_q      <= 1'b0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      cnt_q      <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_meta_q <= req_meta_d;
      req_s_q    <= req_s_d;
      dly_q      <= dly_d;
      ack_q      <= ack_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      cnt_q      <= cnt_d;
      perr_q     <= perr_d;
    end
  end

`ifdef DB_SIGNATURE_EN
  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (capture) sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ r_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;
`endif

  assign r_ack      = ack_q;
  assign data_out   = data_out_q;
  assign data_valid = dv_q;
  assign pkt_count  = cnt_q;
  assign busy       = (state_q != IDLE);
  assign proto_err  = perr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_bucket_sync.sv
// Directed bench for data_bucket_sync: three instances (BL=0, BL=5, BL=10 with a 4-bit counter).
module tb_data_bucket_sync;
  localparam int W = 57;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]          sink_en;
  logic [2:0]          r_req;
  logic [2:0][W-1:0]   r_data;
  logic [2:0]          r_ack;
  logic [2:0][W-1:0]   data_out;
  logic [2:0]          data_valid;
  logic [2:0]          busy;
  logic [2:0]          proto_err;
  logic [2:0][1:0]     dbg_state;
  logic [15:0]         pkt0, pkt1;
  logic [3:0]          pkt2;
`ifdef DB_SIGNATURE_EN
  logic [W-1:0]        sig0, sig1, sig2;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  data_bucket_sync #(.WIDTH(W), .BL(0), .CNT_W(16)) u_bl0 (
    .clk(clk), .rst_n(rst_n), .sink_en(sink_en[0]), .r_req(r_req[0]), .r_data(r_data[0]),
    .r_ack(r_ack[0]), .data_out(data_out[0]), .data_valid(data_valid[0]), .pkt_count(pkt0),
    .busy(busy[0]), .proto_err(proto_err[0]), .dbg_state(dbg_state[0])
`ifdef DB_SIGNATURE_EN
    , .sig(sig0)
`endif
  );

  data_bucket_sync #(.WIDTH(W), .BL(5), .CNT_W(16)) u_bl5 (
    .clk(clk), .rst_n(rst_n), .sink_en(sink_en[1]), .r_req(r_req[1]), .r_data(r_data[1]),
    .r_ack(r_ack[1]), .data_out(data_out[1]), .data_valid(data_valid[1]), .pkt_count(pkt1),
    .busy(busy[1]), .proto_err(proto_err[1]), .dbg_state(dbg_state[1])
`ifdef DB_SIGNATURE_EN
    , .sig(sig1)
`endif
  );

  data_bucket_sync #(.WIDTH(W), .BL(10), .CNT_W(4)) u_bl10 (
    .clk(clk), .rst_n(rst_n), .sink_en(sink_en[2]), .r_req(r_req[2]), .r_data(r_data[2]),
    .r_ack(r_ack[2]), .data_out(data_out[2]), .data_valid(data_valid[2]), .pkt_count(pkt2),
    .busy(busy[2]), .proto_err(proto_err[2]), .dbg_state(dbg_state[2])
`ifdef DB_SIGNATURE_EN
    , .sig(sig2)
`endif
  );

  function automatic logic [15:0] pkt(input int i);
    case (i)
      0:       return pkt0;
      1:       return pkt1;
      default: return {12'd0, pkt2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_pkt();
    logic [24:0] hi;
    logic [31:0] lo;
    hi = 25'($urandom);
    lo = $urandom;
    return {hi, lo};
  endfunction

  // Full 4-phase handshake on instance i; returns the cycle (from r_req rise) of the
  // data_valid pulse and of r_ack rise, both sampled on the falling edge.
  task automatic send(input int i, input logic [W-1:0] d, output int dv_at, output int ack_at);
    int dv_n;
    int fall_at;
    r_data[i] = d;
    r_req[i]  = 1'b1;
    exp_q.push_back(d);
    dv_n = 0; dv_at = -1; ack_at = -1; fall_at = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (data_valid[i]) begin
        dv_n++;
        if (dv_at < 0) dv_at = c;
        if (exp_q.size() > 0) check("data_out", 64'(data_out[i]), 64'(exp_q.pop_front()));
      end
      if (r_ack[i]) begin
        ack_at = c;
        break;
      end
    end
    if (dv_n == 0 && exp_q.size() > 0) void'(exp_q.pop_back());
    check("dv_pulse_count", dv_n, 1);
    check("ack_rise_seen", (ack_at > 0), 1);
    r_req[i] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!r_ack[i]) begin
        fall_at = c;
        break;
      end
    end
    check("ack_fall_within_4", (fall_at >= 1 && fall_at <= 4), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dv_at, ack_at, seen;
    logic [W-1:0] d;

    sink_en = 3'b111;
    r_req   = '0;
    r_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_r_ack", r_ack[i], 0);
      check("rst_data_out", 64'(data_out[i]), 0);
      check("rst_busy", busy[i], 0);
      check("rst_proto_err", proto_err[i], 0);
      check("rst_pkt_count", pkt(i), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single packet, BL=0
    send(0, 57'h1_2345_6789_ABCD, dv_at, ack_at);
    check("bl0_ack_within_4", (ack_at >= 1 && ack_at <= 4), 1);
    check("bl0_ack_after_dv", ack_at - dv_at, 1);
    check("bl0_pkt_count", pkt0, 1);
    check("bl0_data_held", 64'(data_out[0]), 64'(57'h1_2345_6789_ABCD));
    check("bl0_idle_after", dbg_state[0], 0);

    // BL=5: 100 back-to-back packets, ack exactly 6 clk after data_valid
    for (int k = 0; k < 100; k++) begin
      send(1, rand_pkt(), dv_at, ack_at);
      if (k < 4) check("bl5_ack_latency", ack_at - dv_at, 6);
    end
    check("bl5_pkt_count_100", pkt1, 100);

    // sink_en=0 holds off the handshake
    d = rand_pkt();
    sink_en[1] = 1'b0;
    r_data[1]  = d;
    r_req[1]   = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (r_ack[1] || data_valid[1]) seen = 1;
    end
    check("hold_no_ack", seen, 0);
    check("hold_pkt_count", pkt1, 100);
    check("hold_busy", busy[1], 0);
    sink_en[1] = 1'b1;
    @(negedge clk);
    check("hold_release_dv", data_valid[1], 1);
    check("hold_release_data", 64'(data_out[1]), 64'(d));
    check("hold_release_count", pkt1, 101);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (r_ack[1]) begin
        seen = 1;
        break;
      end
    end
    check("hold_ack_rise", seen, 1);
    r_req[1] = 1'b0;
    repeat (6) @(negedge clk);
    check("hold_ack_fall", r_ack[1], 0);

    // Protocol error, BL=10: drop r_req 3 clk after capture
    d = rand_pkt();
    r_data[2] = d;
    r_req[2]  = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (data_valid[2]) begin
        seen = 1;
        break;
      end
    end
    check("perr_capture", seen, 1);
    check("perr_capture_data", 64'(data_out[2]), 64'(d));
    repeat (3) @(negedge clk);
    r_req[2] = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (r_ack[2]) seen = 1;
    end
    check("perr_no_ack", seen, 0);
    check("perr_flag", proto_err[2], 1);
    check("perr_state_idle", dbg_state[2], 0);
    check("perr_busy", busy[2], 0);
    check("perr_pkt_count", pkt2, 1);
    send(2, rand_pkt(), dv_at, ack_at);
    check("perr_next_latency", ack_at - dv_at, 11);
    check("perr_next_count", pkt2, 2);
    check("perr_sticky", proto_err[2], 1);

    // Counter wrap on the 4-bit instance: 17 packets total -> 1
    for (int k = 0; k < 15; k++) send(2, rand_pkt(), dv_at, ack_at);
    check("wrap_pkt_count", pkt2, 1);

    // Async reset in the middle of ACK_HI
    r_data[0] = rand_pkt();
    r_req[0]  = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (r_ack[0]) begin
        seen = 1;
        break;
      end
    end
    check("mid_ack_reached", seen, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_r_ack", r_ack[0], 0);
    check("mid_rst_data_out", 64'(data_out[0]), 0);
    check("mid_rst_pkt_count", pkt0, 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_dv", data_valid[0], 0);
    check("mid_rst_perr", proto_err[2], 0);
    check("mid_rst_pkt2", pkt2, 0);
`ifdef DB_SIGNATURE_EN
    check("mid_rst_sig", 64'(sig0), 0);
`endif
    r_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef DB_SIGNATURE_EN
    send(0, 57'h1, dv_at, ack_at);
    check("sig_after_1", 64'(sig0), 64'h1);
    send(0, 57'h2, dv_at, ack_at);
    check("sig_after_2", 64'(sig0), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
